// File: rtl/serial_ctrl_pkg.sv
// Shared types and defaults for the bit-serial control decoder/sequencer.
// Holds the opcode and multiply-phase enums plus small opcode classifiers.
package serial_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_STALL = 3'b001,
      OP_MULY  = 3'b010,
      OP_MULX  = 3'b011,
      OP_ADD   = 3'b100,
      OP_SUB   = 3'b101,
      OP_WAIT  = 3'b110,
      OP_LDX   = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      PH_SIGN  = 2'b00,
      PH_ALIGN = 2'b01,
      PH_ACC   = 2'b11
   } phase_e;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_ACC_ALIGN   = 3;
   localparam int DEF_GPR_ALIGN_Y = 2;
   localparam int DEF_GPR_ALIGN_X = 1;

   // Serial ops walk the bit counter; everything else parks it at zero.
   function automatic logic is_serial(opcode_e op);
      return op inside {OP_MULY, OP_MULX, OP_ADD, OP_SUB, OP_LDX};
   endfunction

   function automatic logic is_mul(opcode_e op);
      return op inside {OP_MULY, OP_MULX};
   endfunction

   function automatic phase_e next_phase(phase_e ph);
      case (ph)
         PH_SIGN:  return PH_ALIGN;
         PH_ALIGN: return PH_ACC;
         default:  return PH_SIGN;
      endcase
   endfunction

endpackage

// File: rtl/serial_ctrl_if.sv
// Instruction/strobe bundle between serial_ctrl (master) and the
// instruction ROM, switch mux and serial datapath (slave).
interface serial_ctrl_if
   import serial_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   localparam int CNT_W = $clog2(DATA_W);

   logic [2:0]       i_instr;
   logic             i_start;
   logic [CNT_W-1:0] o_con_mux8;
   logic             o_con_mux;
   logic             o_con_muxalu;
   logic             o_con_gpr_shift;
   logic             o_con_gpr_sign;
   logic             o_con_acc_shift;
   logic             o_con_acc_sign;
   logic             o_con_sign_store;
   logic             o_con_blockcarry;
   logic             o_con_check_carry;
   logic             o_con_pcincr;
   logic             o_con_sub;
   logic             o_con_carry_set;
   logic             o_busy;

   modport master (
      input  i_instr, i_start,
      output o_con_mux8, o_con_mux, o_con_muxalu, o_con_gpr_shift,
             o_con_gpr_sign, o_con_acc_shift, o_con_acc_sign,
             o_con_sign_store, o_con_blockcarry, o_con_check_carry,
             o_con_pcincr, o_con_sub, o_con_carry_set, o_busy
   );

   modport slave (
      output i_instr, i_start,
      input  o_con_mux8, o_con_mux, o_con_muxalu, o_con_gpr_shift,
             o_con_gpr_sign, o_con_acc_shift, o_con_acc_sign,
             o_con_sign_store, o_con_blockcarry, o_con_check_carry,
             o_con_pcincr, o_con_sub, o_con_carry_set, o_busy
   );

endinterface

// File: rtl/serial_ctrl_bit_counter.sv
// Bit position counter for the serial word; wraps explicitly at DATA_W-1
// so any word length works, not only powers of two.
module serial_bit_counter
   import serial_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      inc,
   input  logic                      clr,
   output logic [$clog2(DATA_W)-1:0] count,
   output logic                      last
);
   localparam int CNT_W = $clog2(DATA_W);

   assign last = (count == CNT_W'(DATA_W - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= last ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_ctrl.sv
// Control decoder and multiply phase sequencer for the bit-serial datapath.
// Define SERIAL_CTRL_SUB_EN to make opcode 101 a true subtract (else it aliases add).
module serial_ctrl
   import serial_ctrl_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ACC_ALIGN   = DEF_ACC_ALIGN,
   parameter int GPR_ALIGN_Y = DEF_GPR_ALIGN_Y,
   parameter int GPR_ALIGN_X = DEF_GPR_ALIGN_X
) (
   input logic           i_clk,
   input logic           i_rst_n,
   serial_ctrl_if.master bus
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W:0] ACC_AL   = (CNT_W+1)'(ACC_ALIGN);
   localparam logic [CNT_W:0] GPR_AL_Y = (CNT_W+1)'(GPR_ALIGN_Y);
   localparam logic [CNT_W:0] GPR_AL_X = (CNT_W+1)'(GPR_ALIGN_X);

   opcode_e          op;
   phase_e           phase;
   phase_e           phase_nxt;
   logic [CNT_W-1:0] count;
   logic             last;
   logic             first;
   logic             cnt_inc;
   logic             cnt_clr;

   logic con_mux;
   logic con_muxalu;
   logic con_gpr_shift;
   logic con_gpr_sign;
   logic con_acc_shift;
   logic con_acc_sign;
   logic con_sign_store;
   logic con_blockcarry;
   logic con_check_carry;
   logic con_pcincr;
   logic con_sub;
   logic con_carry_set;

   assign op    = opcode_e'(bus.i_instr);
   assign first = (count == '0);

   // Clears only come from the non-serial ops, so they never meet an increment.
   assign cnt_inc = is_serial(op);
   assign cnt_clr = con_pcincr && !is_serial(op);

   serial_bit_counter #(
      .DATA_W (DATA_W)
   ) u_bit_counter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .inc     (cnt_inc),
      .clr     (cnt_clr),
      .count   (count),
      .last    (last)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase <= PH_SIGN;
      end else begin
         phase <= phase_nxt;
      end
   end

   always_comb begin
      phase_nxt = PH_SIGN;
      if (is_mul(op)) begin
         phase_nxt = last ? next_phase(phase) : phase;
      end
   end

   // Strobes are forced low while reset is held, even for the start-driven ops.
   always_comb begin
      con_mux         = 1'b0;
      con_muxalu      = 1'b0;
      con_gpr_shift   = 1'b0;
      con_gpr_sign    = 1'b0;
      con_acc_shift   = 1'b0;
      con_acc_sign    = 1'b0;
      con_sign_store  = 1'b0;
      con_blockcarry  = 1'b0;
      con_check_carry = 1'b0;
      con_pcincr      = 1'b0;
      con_sub         = 1'b0;
      con_carry_set   = 1'b0;
      if (i_rst_n) begin
         case (op)
            OP_NOP:   con_pcincr = bus.i_start;
            OP_STALL: con_pcincr = 1'b1;
            OP_WAIT:  con_pcincr = !bus.i_start;
            OP_MULY, OP_MULX: begin
               case (phase)
                  PH_SIGN: begin
                     con_muxalu     = 1'b1;
                     con_gpr_shift  = 1'b1;
                     con_acc_shift  = 1'b1;
                     con_sign_store = last;
                  end
                  PH_ALIGN: begin
                     con_gpr_sign  = 1'b1;
                     con_acc_sign  = 1'b1;
                     con_acc_shift = ({1'b0, count} < ACC_AL);
                     con_gpr_shift = (op == OP_MULY) ? ({1'b0, count} < GPR_AL_Y)
                                                     : ({1'b0, count} < GPR_AL_X);
                  end
                  PH_ACC: begin
                     con_gpr_shift   = 1'b1;
                     con_acc_shift   = 1'b1;
                     con_check_carry = first;
                     con_blockcarry  = first;
                     con_pcincr      = last;
                  end
                  default: ;
               endcase
            end
            OP_ADD: begin
               con_gpr_shift  = 1'b1;
               con_acc_shift  = 1'b1;
               con_blockcarry = first;
               con_pcincr     = last;
            end
            OP_SUB: begin
               con_gpr_shift = 1'b1;
               con_acc_shift = 1'b1;
               con_pcincr    = last;
`ifdef SERIAL_CTRL_SUB_EN
               con_sub       = 1'b1;
               con_carry_set = first;
`else
               con_blockcarry = first;
`endif
            end
            OP_LDX: begin
               con_mux       = 1'b1;
               con_gpr_shift = 1'b1;
               con_pcincr    = last;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_con_mux8        = i_rst_n ? count : '0;
   assign bus.o_con_mux         = con_mux;
   assign bus.o_con_muxalu      = con_muxalu;
   assign bus.o_con_gpr_shift   = con_gpr_shift;
   assign bus.o_con_gpr_sign    = con_gpr_sign;
   assign bus.o_con_acc_shift   = con_acc_shift;
   assign bus.o_con_acc_sign    = con_acc_sign;
   assign bus.o_con_sign_store  = con_sign_store;
   assign bus.o_con_blockcarry  = con_blockcarry;
   assign bus.o_con_check_carry = con_check_carry;
   assign bus.o_con_pcincr      = con_pcincr;
   assign bus.o_con_sub         = con_sub;
   assign bus.o_con_carry_set   = con_carry_set;
   assign bus.o_busy            = i_rst_n && ((count != '0) || (phase != PH_SIGN));

endmodule

// File: tb/tb_serial_ctrl.sv
// Self-checking bench for serial_ctrl: DATA_W=8 and DATA_W=12 instances,
// directed scenarios followed by random opcode streams against a cycle-position model.
module tb_serial_ctrl;

   localparam int N0 = 8;
   localparam int N1 = 12;
   localparam int RAND_CYCLES = 3000;

   localparam int B_BUSY = 0;
   localparam int B_CSET = 1;
   localparam int B_SUB  = 2;
   localparam int B_PC   = 3;
   localparam int B_CHK  = 4;
   localparam int B_BLK  = 5;
   localparam int B_SST  = 6;
   localparam int B_ASG  = 7;
   localparam int B_ASH  = 8;
   localparam int B_GSG  = 9;
   localparam int B_GSH  = 10;
   localparam int B_MALU = 11;
   localparam int B_MUX  = 12;

   logic       clk = 1'b0;
   logic [2:0] instr_d [2];
   logic       start_d [2];
   logic       rst_d   [2];
   logic [2:0] prev_instr [2];
   int         pos [2];
   int         n_total = 0;
   int         n_pass  = 0;
   logic [20:0] act [2];

   always #5 clk = ~clk;

   serial_ctrl_if #(.DATA_W(N0)) bus0 ();
   serial_ctrl_if #(.DATA_W(N1)) bus1 ();

   assign bus0.i_instr = instr_d[0];
   assign bus0.i_start = start_d[0];
   assign bus1.i_instr = instr_d[1];
   assign bus1.i_start = start_d[1];

   serial_ctrl #(.DATA_W(N0), .ACC_ALIGN(3), .GPR_ALIGN_Y(2), .GPR_ALIGN_X(1)) dut0 (
      .i_clk   (clk),
      .i_rst_n (rst_d[0]),
      .bus     (bus0)
   );

   serial_ctrl #(.DATA_W(N1), .ACC_ALIGN(3), .GPR_ALIGN_Y(2), .GPR_ALIGN_X(1)) dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_d[1]),
      .bus     (bus1)
   );

   assign act[0] = {5'd0, bus0.o_con_mux8, bus0.o_con_mux, bus0.o_con_muxalu,
                    bus0.o_con_gpr_shift, bus0.o_con_gpr_sign, bus0.o_con_acc_shift,
                    bus0.o_con_acc_sign, bus0.o_con_sign_store, bus0.o_con_blockcarry,
                    bus0.o_con_check_carry, bus0.o_con_pcincr, bus0.o_con_sub,
                    bus0.o_con_carry_set, bus0.o_busy};
   assign act[1] = {4'd0, bus1.o_con_mux8, bus1.o_con_mux, bus1.o_con_muxalu,
                    bus1.o_con_gpr_shift, bus1.o_con_gpr_sign, bus1.o_con_acc_shift,
                    bus1.o_con_acc_sign, bus1.o_con_sign_store, bus1.o_con_blockcarry,
                    bus1.o_con_check_carry, bus1.o_con_pcincr, bus1.o_con_sub,
                    bus1.o_con_carry_set, bus1.o_busy};

   function automatic int n_of(int d);
      return (d == 0) ? N0 : N1;
   endfunction

   // Expected outputs from the position p (cycles into the current instruction).
   function automatic logic [20:0] model_out(int n, int p, logic [2:0] op, logic st, logic rst);
      logic [20:0] r;
      int cnt, ph;
      bit lst, fst;
      r = '0;
      if (!rst) return r;
      cnt = p % n;
      ph  = p / n;
      lst = (cnt == n - 1);
      fst = (cnt == 0);
      case (op)
         3'b000: r[B_PC] = st;
         3'b001: r[B_PC] = 1'b1;
         3'b110: r[B_PC] = !st;
         3'b010, 3'b011: begin
            if (ph == 0) begin
               r[B_MALU] = 1'b1; r[B_GSH] = 1'b1; r[B_ASH] = 1'b1; r[B_SST] = lst;
            end else if (ph == 1) begin
               r[B_GSG] = 1'b1; r[B_ASG] = 1'b1;
               r[B_ASH] = (cnt < 3);
               r[B_GSH] = (cnt < ((op == 3'b010) ? 2 : 1));
            end else begin
               r[B_GSH] = 1'b1; r[B_ASH] = 1'b1;
               r[B_CHK] = fst; r[B_BLK] = fst; r[B_PC] = lst;
            end
         end
         3'b100: begin
            r[B_GSH] = 1'b1; r[B_ASH] = 1'b1; r[B_BLK] = fst; r[B_PC] = lst;
         end
         3'b101: begin
            r[B_GSH] = 1'b1; r[B_ASH] = 1'b1; r[B_PC] = lst;
`ifdef SERIAL_CTRL_SUB_EN
            r[B_SUB] = 1'b1; r[B_CSET] = fst;
`else
            r[B_BLK] = fst;
`endif
         end
         default: begin
            r[B_MUX] = 1'b1; r[B_GSH] = 1'b1; r[B_PC] = lst;
         end
      endcase
      r[B_BUSY]  = (p != 0);
      r[20:13]   = 8'(cnt);
      return r;
   endfunction

   function automatic int next_pos(int n, int p, logic [2:0] op, logic st, logic rst);
      logic [20:0] o;
      int lim;
      if (!rst) return 0;
      if (op inside {3'b010, 3'b011, 3'b100, 3'b101, 3'b111}) begin
         lim = (op == 3'b010 || op == 3'b011) ? 3 * n : n;
         return (p + 1 == lim) ? 0 : p + 1;
      end
      o = model_out(n, p, op, st, rst);
      return o[B_PC] ? 0 : p;
   endfunction

   task automatic check_output(string name, logic [31:0] actual, logic [31:0] required);
      n_total++;
      if (actual === required) n_pass++;
      else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
   endtask

   task automatic apply_stimulus(int d, logic [2:0] op, logic st);
      instr_d[d] = op;
      start_d[d] = st;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic bitv(int d, int b);
      return act[d][b];
   endfunction

   function automatic logic [7:0] cnt_of(int d);
      return act[d][20:13];
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         pos[d] <= next_pos(n_of(d), pos[d], instr_d[d], start_d[d], rst_d[d]);
   end

   // Single compare process: every cycle, both instances against the model.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         check_output($sformatf("model_dut%0d", d), 32'(act[d]),
                      32'(model_out(n_of(d), pos[d], instr_d[d], start_d[d], rst_d[d])));
         assert (!(rst_d[d] && pos[d] != 0 && instr_d[d] != prev_instr[d]))
            else $error("[TB] illegal opcode change while busy on dut%0d", d);
         prev_instr[d] = instr_d[d];
      end
   end

   task automatic run_mul(logic [2:0] op, int gpr_al);
      apply_stimulus(0, op, 1'b0);
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         check_output("mul_sign_store", bitv(0, B_SST), i == 7);
         if (i >= 8 && i < 16) begin
            check_output("mul_align_gpr_shift", bitv(0, B_GSH), (i - 8) < gpr_al);
            check_output("mul_align_acc_shift", bitv(0, B_ASH), (i - 8) < 3);
         end
         check_output("mul_check_carry", bitv(0, B_CHK), i == 16);
         check_output("mul_pcincr", bitv(0, B_PC), i == 23);
         step();
      end
   endtask

   initial begin
      logic [20:0] m;
      for (int d = 0; d < 2; d++) begin
         instr_d[d] = 3'b000; start_d[d] = 1'b0; rst_d[d] = 1'b1;
         prev_instr[d] = 3'b000; pos[d] = 0;
      end
      m = model_out(8, 23, 3'b010, 1'b0, 1'b1);
      check_output("pin_model_mul_end", {m[20:13], 7'd0, m[B_PC]}, {8'd7, 8'd1});
      m = model_out(12, 0, 3'b100, 1'b0, 1'b1);
      check_output("pin_model_add_first", {m[B_BLK], m[B_BUSY]}, 2'b10);
      #1;
      rst_d[0] = 1'b0; rst_d[1] = 1'b0;
      apply_stimulus(0, 3'b001, 1'b0);
      @(negedge clk);
      check_output("reset_outputs_zero", 32'(act[0]), 32'd0);
      step();
      rst_d[0] = 1'b1; rst_d[1] = 1'b1;

      apply_stimulus(0, 3'b111, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_output("ldx_mux", bitv(0, B_MUX), 1'b1);
         check_output("ldx_gpr_shift", bitv(0, B_GSH), 1'b1);
         check_output("ldx_pcincr", bitv(0, B_PC), i == 7);
         check_output("ldx_count", 32'(cnt_of(0)), 32'(i));
         step();
      end

      apply_stimulus(0, 3'b000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("nop_idle_pcincr", bitv(0, B_PC), 1'b0);
         check_output("nop_idle_count", 32'(cnt_of(0)), 32'd0);
         step();
      end
      apply_stimulus(0, 3'b000, 1'b1);
      @(negedge clk);
      check_output("nop_start_pcincr", bitv(0, B_PC), 1'b1);
      step();
      apply_stimulus(0, 3'b000, 1'b0);
      @(negedge clk);
      check_output("nop_after_count", 32'(cnt_of(0)), 32'd0);
      step();

      run_mul(3'b010, 2);
      run_mul(3'b011, 1);

      apply_stimulus(0, 3'b010, 1'b0);
      for (int i = 0; i < 12; i++) step();
      rst_d[0] = 1'b0;
      @(negedge clk);
      check_output("reset_mid_mul", 32'(act[0]), 32'd0);
      step();
      step();
      rst_d[0] = 1'b1;
      @(negedge clk);
      check_output("restart_count", 32'(cnt_of(0)), 32'd0);
      check_output("restart_sign_phase", {bitv(0, B_MALU), bitv(0, B_GSG)}, 2'b10);
      for (int i = 0; i < 23; i++) step();
      @(negedge clk);
      check_output("restart_pcincr", {cnt_of(0), bitv(0, B_PC)}, {8'd7, 1'b1});
      step();
      apply_stimulus(0, 3'b000, 1'b0);

      apply_stimulus(1, 3'b100, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check_output("add12_count", 32'(cnt_of(1)), 32'(i));
         check_output("add12_pcincr", bitv(1, B_PC), i == 11);
         check_output("add12_blockcarry", bitv(1, B_BLK), i == 0);
         step();
      end
      apply_stimulus(1, 3'b000, 1'b0);
      @(negedge clk);
      check_output("add12_wrap", 32'(cnt_of(1)), 32'd0);
      step();

      apply_stimulus(0, 3'b101, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
`ifdef SERIAL_CTRL_SUB_EN
         check_output("sub_sub", bitv(0, B_SUB), 1'b1);
         check_output("sub_carry_set", bitv(0, B_CSET), i == 0);
         check_output("sub_blockcarry", bitv(0, B_BLK), 1'b0);
`else
         check_output("sub_alias_sub", bitv(0, B_SUB), 1'b0);
         check_output("sub_alias_carry_set", bitv(0, B_CSET), 1'b0);
         check_output("sub_alias_blockcarry", bitv(0, B_BLK), i == 0);
`endif
         check_output("sub_pcincr", bitv(0, B_PC), i == 7);
         step();
      end
      apply_stimulus(0, 3'b000, 1'b0);

      for (int c = 0; c < RAND_CYCLES; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (!rst_d[d]) begin
               if ($urandom_range(0, 2) == 0) rst_d[d] = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
               rst_d[d] = 1'b0;
            end else if (pos[d] == 0 && $urandom_range(0, 3) == 0) begin
               instr_d[d] = 3'($urandom_range(0, 7));
            end
            start_d[d] = ($urandom_range(0, 3) == 0);
         end
         step();
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_ctrl.md
# serial_ctrl

Parametrised control decoder and sequencer for the bit-serial datapath. It decodes the 3-bit instruction and owns the bit counter internally, which the previous decoder took from outside. It also owns the multiply phase machine, and drives every datapath control strobe plus the PC increment. It sits between the instruction ROM/PC and the GPR/ACC shift registers, the ALU and the switch input mux.

## Interface
- DATA_W, 8, serial word length in bits; legal range 4..64.
- ACC_ALIGN, 3, ACC shift cycles in the multiply align phase.
- GPR_ALIGN_Y, 2, GPR shift cycles in the align phase for Y*d.
- GPR_ALIGN_X, 1, GPR shift cycles in the align phase for X*(1-d).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_instr  in  3  current opcode; must be held stable while o_busy=1.
- i_start  in  1  start switch, already synchronised.
- o_con_mux8  out  $clog2(DATA_W)  switch-bit index; equals the bit count.
- o_con_mux, o_con_muxalu, o_con_gpr_shift, o_con_gpr_sign, o_con_acc_shift, o_con_acc_sign, o_con_sign_store, o_con_blockcarry, o_con_check_carry, o_con_pcincr  out  1 each  datapath strobes.
- o_con_sub  out  1  ALU subtract: invert GPR operand.
- o_con_carry_set  out  1  force ALU carry-in to 1 for this cycle.
- o_busy  out  1  a serial instruction is mid-flight: count!=0 or phase!=PH_SIGN.

## Operation
- Registers: count (CNT_W bits) and phase (PH_SIGN, PH_ALIGN, PH_ACC). Both reset to 0/PH_SIGN. All outputs are combinational from count, phase, i_instr and i_start. While reset is asserted, all outputs are 0.
- last = (count == DATA_W-1).
- Serial ops (010, 011, 10?, 111): count increments every cycle and wraps from DATA_W-1 to 0 explicitly. Any DATA_W is legal; wrap is not tied to a power of 2.
- 000 NOP: if i_start, assert pcincr and clear count. Otherwise hold.
- 001 stall: assert pcincr and clear count every cycle.
- 110 wait-off: if !i_start, assert pcincr and clear count.
- Non-multiply ops force phase to PH_SIGN.
- 010 Y*d and 011 X*(1-d) each take 3*DATA_W cycles. The phase advances on last: PH_SIGN→PH_ALIGN→PH_ACC→PH_SIGN.
  - PH_SIGN: muxalu=1, gpr_shift=1, acc_shift=1. sign_store=1 on last.
  - PH_ALIGN: gpr_sign=1, acc_sign=1. acc_shift=1 while count<ACC_ALIGN. gpr_shift=1 while count<GPR_ALIGN_Y (010) or count<GPR_ALIGN_X (011).
  - PH_ACC: gpr_shift=1, acc_shift=1. At count 0: check_carry=1, blockcarry=1. On last: pcincr=1.
- 100 Add: gpr_shift=1, acc_shift=1. At count 0: blockcarry=1. On last: pcincr=1.
- 101: Subtract when SERIAL_CTRL_SUB_EN is defined (see Configuration); otherwise identical to Add.
- 111 Load X: mux=1, gpr_shift=1. On last: pcincr=1.
- Strobes not listed for an opcode/phase are 0.

## Timing
- Decode is zero-latency: strobes are valid in the same cycle as i_instr/count.
- pcincr is asserted for exactly one cycle, at the final bit of the instruction. The next opcode is presented the following cycle, with count=0.
- Reset asserted mid-instruction: count and phase clear immediately. On deassertion, the current opcode restarts from bit 0, PH_SIGN.
- An opcode change while o_busy=1 is illegal. The bench flags it with an assertion. The RTL does not recover from it.
- Clear and increment never coincide. Clears happen only on non-serial ops.

## Configuration
- SERIAL_CTRL_SUB_EN defined: opcode 101 has the Add strobes plus o_con_sub=1 on all DATA_W cycles. At count 0 it asserts carry_set=1 instead of blockcarry. This gives two's-complement ACC−GPR.
- SERIAL_CTRL_SUB_EN undefined: 101 aliases Add. o_con_sub and o_con_carry_set are tied 0.

## Structure
- Package serial_ctrl_pkg holds:
  - the opcode enum (OP_NOP, OP_STALL, OP_MULY, OP_MULX, OP_ADD, OP_SUB, OP_WAIT, OP_LDX);
  - the phase enum (PH_SIGN=2'b00, PH_ALIGN=2'b01, PH_ACC=2'b11);
  - default alignment constants.
- Sub-module serial_bit_counter (parameter DATA_W) provides:
  - inputs: inc and clr;
  - outputs: count and last;
  - async active-low reset.

## Test plan
1. DATA_W=8. Reset, then hold 111 for 8 cycles → mux=1 and gpr_shift=1 throughout. pcincr only at count 7. count returns to 0.
2. 010 for 24 cycles → sign_store at cycle 7. Align phase: gpr_shift at counts 0–1 and acc_shift at counts 0–2. check_carry+blockcarry at cycle 16. pcincr at cycle 23. Repeat with 011 → align-phase gpr_shift at count 0 only.
3. 000 with i_start=0 for 5 cycles → no pcincr, count held. Raise i_start → pcincr=1 the same cycle, count=0 next cycle.
4. Pull i_rst_n low at cycle 12 of a 010 → all outputs 0 and o_busy=0. After release, the sequence restarts at PH_SIGN count 0.
5. DATA_W=12, opcode 100 → count wraps 11→0. pcincr at cycle 11. blockcarry only at cycle 0.
6. SERIAL_CTRL_SUB_EN defined, opcode 101 → sub=1 for 8 cycles, carry_set=1 at count 0, blockcarry=0. Without the macro → behaves as case 5.
